bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Three-channel (ir/dr/dw) to single memory port arbiter, priority dw > dr > ir.
// Request-to-response is 4 cycles with zero-wait memory; one pending entry per channel; all outputs hold until accepted.
module bus_arbiter #(
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ir_addr_valid,
  input  logic [31:0] ir_addr,
  output logic        ir_addr_ready,
  output logic        ir_data_valid,
  output logic [31:0] ir_data,
  input  logic        ir_data_ready,

  input  logic        dr_addr_valid,
  input  logic [31:0] dr_addr,
  output logic        dr_addr_ready,
  output logic        dr_data_valid,
  output logic [31:0] dr_data,
  input  logic        dr_data_ready,

  input  logic        dw_data_addr_valid,
  input  logic [31:0] dw_addr,
  input  logic [31:0] dw_data,
  input  logic [3:0]  dw_strobe,
  output logic        dw_data_addr_ready,
  output logic        dw_resp_valid,
  output logic        dw_resp,
  input  logic        dw_resp_ready,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {CH_IR, CH_DR, CH_DW} chan_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_t;

  localparam logic [31:0] WORD_MASK = ~32'h3;

  state_t      state, state_nxt;
  chan_t       grant;
  req_t        ir_q, dr_q, dw_q, sel;
  logic        ir_pend, dr_pend, dw_pend;
  logic        ir_acc, dr_acc, dw_acc;
  logic        oor, resp_rdy, resp_done;
  logic [31:0] rdata_q;
  logic        resp_ok_q;

  // Readies depend only on pending state (and reset), never on the valids.
  assign ir_addr_ready      = !rst && !ir_pend;
  assign dr_addr_ready      = !rst && !dr_pend;
  assign dw_data_addr_ready = !rst && !dw_pend;

  assign ir_acc = ir_addr_valid      && ir_addr_ready;
  assign dr_acc = dr_addr_valid      && dr_addr_ready;
  assign dw_acc = dw_data_addr_valid && dw_data_addr_ready;

  always_ff @(posedge clk) begin
    if (ir_acc) ir_q <= '{addr: ir_addr & WORD_MASK, data: 32'h0, strb: 4'h0};
    if (dr_acc) dr_q <= '{addr: dr_addr & WORD_MASK, data: 32'h0, strb: 4'h0};
    if (dw_acc) dw_q <= '{addr: dw_addr & WORD_MASK, data: dw_data, strb: dw_strobe};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_pend <= 1'b0;
      dr_pend <= 1'b0;
      dw_pend <= 1'b0;
    end else begin
      if (ir_acc)                               ir_pend <= 1'b1;
      else if (resp_done && grant == CH_IR)     ir_pend <= 1'b0;
      if (dr_acc)                               dr_pend <= 1'b1;
      else if (resp_done && grant == CH_DR)     dr_pend <= 1'b0;
      if (dw_acc)                               dw_pend <= 1'b1;
      else if (resp_done && grant == CH_DW)     dw_pend <= 1'b0;
    end
  end

  always_comb begin
    sel      = ir_q;
    resp_rdy = ir_data_ready;
    case (grant)
      CH_DR: begin
        sel      = dr_q;
        resp_rdy = dr_data_ready;
      end
      CH_DW: begin
        sel      = dw_q;
        resp_rdy = dw_resp_ready;
      end
      default: begin
        sel      = ir_q;
        resp_rdy = ir_data_ready;
      end
    endcase
  end

  assign oor       = sel.addr >= MEM_SIZE;
  assign resp_done = (state == RESP) && resp_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ir_pend || dr_pend || dw_pend) state_nxt = ISSUE;
      ISSUE:   if (oor) state_nxt = RESP;
               else if (mem_ready) state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = RESP;
      RESP:    if (resp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is chosen only in IDLE, so it stays fixed through ISSUE/WAIT/RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= CH_IR;
      rdata_q   <= 32'h0;
      resp_ok_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (dw_pend)      grant <= CH_DW;
        else if (dr_pend) grant <= CH_DR;
        else if (ir_pend) grant <= CH_IR;
      end
      if (state == ISSUE && oor) begin
        rdata_q   <= 32'h0;
        resp_ok_q <= 1'b0;
      end
      if (state == WAIT && mem_rvalid) begin
        rdata_q   <= mem_rdata;
        resp_ok_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_wstrb     = 4'h0;
    ir_data_valid = 1'b0;
    dr_data_valid = 1'b0;
    dw_resp_valid = 1'b0;
    ir_data       = rdata_q;
    dr_data       = rdata_q;
    dw_resp       = resp_ok_q;
    if (!rst) begin
      case (state)
        ISSUE: begin
          if (!oor) begin
            mem_req   = 1'b1;
            mem_we    = (grant == CH_DW);
            mem_addr  = sel.addr;
            mem_wdata = sel.data;
            mem_wstrb = sel.strb;
          end
        end
        RESP: begin
          ir_data_valid = (grant == CH_IR);
          dr_data_valid = (grant == CH_DR);
          dw_resp_valid = (grant == CH_DW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: memory model plus response monitor check against
// expectation queues filled when each request is driven.
module tb_bus_arbiter;

  localparam logic [31:0] MEM_SIZE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic        dw_data_addr_valid, dw_data_addr_ready, dw_resp_valid, dw_resp, dw_resp_ready;
  logic [31:0] dw_addr, dw_data;
  logic [3:0]  dw_strobe;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  bus_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr(ir_addr), .ir_addr_ready(ir_addr_ready),
    .ir_data_valid(ir_data_valid), .ir_data(ir_data), .ir_data_ready(ir_data_ready),
    .dr_addr_valid(dr_addr_valid), .dr_addr(dr_addr), .dr_addr_ready(dr_addr_ready),
    .dr_data_valid(dr_data_valid), .dr_data(dr_data), .dr_data_ready(dr_data_ready),
    .dw_data_addr_valid(dw_data_addr_valid), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_strobe(dw_strobe), .dw_data_addr_ready(dw_data_addr_ready),
    .dw_resp_valid(dw_resp_valid), .dw_resp(dw_resp), .dw_resp_ready(dw_resp_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  typedef struct {
    int          ch;
    logic [31:0] dat;
  } rsp_t;

  mreq_t exp_mem[$];
  rsp_t  exp_rsp[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_xfer[3];
  int    mem_lat = 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic exp_read(input int ch, input logic [31:0] a);
    exp_mem.push_back(mreq_t'{1'b0, a, 32'h0, 4'h0});
    exp_rsp.push_back(rsp_t'{ch, mem_fn(a)});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_mem.push_back(mreq_t'{1'b1, a, d, s});
    exp_rsp.push_back(rsp_t'{2, 32'h1});
  endtask

  task automatic exp_oor(input int ch);
    exp_rsp.push_back(rsp_t'{ch, 32'h0});
  endtask

  // Memory model: checks every accepted request and answers after mem_lat cycles.
  initial begin : mem_model
    mreq_t e, held;
    logic  hold;
    hold       = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("mem_hold_req", 32'(mem_req), 32'h1);
        check("mem_hold_addr", mem_addr, held.addr);
        check("mem_hold_we", 32'(mem_we), 32'(held.we));
        check("mem_hold_wdata", mem_wdata, held.wdata);
        check("mem_hold_wstrb", 32'(mem_wstrb), 32'(held.wstrb));
      end
      hold = 1'b0;
      if (mem_req && !mem_ready) begin
        hold = 1'b1;
        held = mreq_t'{mem_we, mem_addr, mem_wdata, mem_wstrb};
      end else if (mem_req) begin
        check("mem_req_expected", 32'(mem_req), 32'(exp_mem.size() != 0));
        if (exp_mem.size() != 0) begin
          e = exp_mem.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) begin
            check("mem_wdata", mem_wdata, e.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          end
        end else begin
          e = mreq_t'{1'b0, mem_addr, 32'h0, 4'h0};
        end
        @(posedge clk);
        for (int i = 1; i < mem_lat; i++) @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = e.we ? 32'h0 : mem_fn(e.addr);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
      end
    end
  end

  // Response monitor: one-hot valids, stability under backpressure, in-order results.
  initial begin : rsp_mon
    logic [2:0]  vld, hold_vld;
    logic [31:0] d, hold_dat;
    logic        rdy, ardy, hold;
    int          ch;
    rsp_t        e;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) n_xfer[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      vld = {dw_resp_valid, dr_data_valid, ir_data_valid};
      if (vld != 3'b000) check("rsp_onehot", 32'($onehot0(vld)), 32'h1);
      if (vld[2]) begin
        ch = 2; d = 32'(dw_resp); rdy = dw_resp_ready; ardy = dw_data_addr_ready;
      end else if (vld[1]) begin
        ch = 1; d = dr_data; rdy = dr_data_ready; ardy = dr_addr_ready;
      end else begin
        ch = 0; d = ir_data; rdy = ir_data_ready; ardy = ir_addr_ready;
      end
      if (hold) begin
        check("rsp_hold_vld", 32'(vld), 32'(hold_vld));
        check("rsp_hold_dat", d, hold_dat);
      end
      hold = 1'b0;
      if (vld != 3'b000) begin
        if (!rdy) begin
          hold     = 1'b1;
          hold_vld = vld;
          hold_dat = d;
        end else begin
          n_xfer[ch]++;
          check("addr_rdy_while_pending", 32'(ardy), 32'h0);
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 32'(vld), 32'h0);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_channel", 32'(ch), 32'(e.ch));
            check("rsp_data", d, e.dat);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1);
  end

  task automatic issue(input logic di, input logic [31:0] ia,
                       input logic dd, input logic [31:0] da,
                       input logic dv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws);
    @(posedge clk);
    #1;
    ir_addr_valid = di; ir_addr = ia;
    dr_addr_valid = dd; dr_addr = da;
    dw_data_addr_valid = dv; dw_addr = wa; dw_data = wd; dw_strobe = ws;
    @(negedge clk);
    check("addr_rdy_at_issue",
          32'({dw_data_addr_ready & dv, dr_addr_ready & dd, ir_addr_ready & di}),
          32'({dv, dd, di}));
    @(posedge clk);
    #1;
    ir_addr_valid = 1'b0;
    dr_addr_valid = 1'b0;
    dw_data_addr_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_outstanding", 32'(exp_rsp.size() + exp_mem.size()), 32'h0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] readies();
    return 32'({dw_data_addr_ready, dr_addr_ready, ir_addr_ready});
  endfunction

  initial begin : stim
    int   lq, lr, base;
    logic seen;
    rst = 1'b1;
    ir_addr_valid = 1'b0; ir_addr = 32'h0; ir_data_ready = 1'b1;
    dr_addr_valid = 1'b0; dr_addr = 32'h0; dr_data_ready = 1'b1;
    dw_data_addr_valid = 1'b0; dw_addr = 32'h0; dw_data = 32'h0; dw_strobe = 4'h0;
    dw_resp_ready = 1'b1;
    mem_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_rsp_valids", 32'({dw_resp_valid, dr_data_valid, ir_data_valid}), 32'h0);
    check("rst_addr_readies", readies(), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_addr_readies", readies(), 32'h7);

    // ir read with measured latency
    exp_read(0, 32'h100);
    issue(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    lq = 0; lr = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_req && lq == 0) lq = k;
      if (ir_data_valid && lr == 0) lr = k;
    end
    check("latency_mem_req", 32'(lq), 32'd2);
    check("latency_rsp_valid", 32'(lr), 32'd4);
    drain();

    // all three channels at once: order dw, dr, ir
    exp_write(32'h300, 32'h1122_3344, 4'hF);
    exp_read(1, 32'h204);
    exp_read(0, 32'h40C);
    issue(1'b1, 32'h40C, 1'b1, 32'h207, 1'b1, 32'h300, 32'h1122_3344, 4'hF);
    @(negedge clk);
    check("all_pending_readies", readies(), 32'h0);
    drain();
    check("freed_readies", readies(), 32'h7);

    // unaligned partial write
    exp_write(32'h100, 32'h0000_AB00, 4'b0100);
    issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 32'h0000_AB00, 4'b0100);
    drain();

    // range boundaries
    exp_read(1, 32'h80);
    issue(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0);
    drain();
    exp_read(1, MEM_SIZE - 32'h4);
    issue(1'b0, 32'h0, 1'b1, MEM_SIZE - 32'h4, 1'b0, 32'h0, 32'h0, 4'h0);
    drain();
    exp_oor(1);
    issue(1'b0, 32'h0, 1'b1, MEM_SIZE, 1'b0, 32'h0, 32'h0, 4'h0);
    drain();
    exp_rsp.push_back(rsp_t'{2, 32'h0});
    issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, MEM_SIZE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    drain();

    // memory stall then response backpressure
    mem_ready = 1'b0;
    dr_data_ready = 1'b0;
    base = n_xfer[1];
    exp_read(1, 32'h500);
    issue(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    check("stall_mem_req_seen", 32'(mem_req), 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    for (int k = 0; k < 20 && !dr_data_valid; k++) @(negedge clk);
    check("stall_rsp_seen", 32'(dr_data_valid), 32'h1);
    @(negedge clk);
    @(posedge clk);
    #1 dr_data_ready = 1'b1;
    drain();
    check("dr_single_transfer", 32'(n_xfer[1] - base), 32'h1);

    // reset while waiting on memory; late rvalid must be ignored
    mem_lat = 4;
    exp_mem.push_back(mreq_t'{1'b0, 32'h600, 32'h0, 4'h0});
    issue(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 20 && exp_mem.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    check("rst_mid_readies", readies(), 32'h7);
    for (int k = 0; k < 8; k++) begin
      seen |= ir_data_valid | dr_data_valid | dw_resp_valid;
      @(negedge clk);
    end
    check("no_rsp_after_rst", 32'(seen), 32'h0);
    mem_lat = 1;
    exp_read(1, 32'h700);
    issue(1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h0, 32'h0, 4'h0);
    drain();

    check("final_queues_empty", 32'(exp_mem.size() + exp_rsp.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
